// File: rtl/apb_pkg.sv
// Shared types and constants for the single-slave APB master.
// Latency: none (types, constants and a pure combinational helper).
// Backpressure: not applicable.
package apb_pkg;

  // Transfer phases; encoding 2'b11 is unused and behaves as ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;

  // Byte window owned by the downstream slave.
  localparam logic [31:0] SLAVE_ADDR = 32'h0000_A000;
  localparam logic [31:0] SLAVE_SIZE = 32'h0000_1000;

  // Wide enough for the largest legal timeout (255).
  localparam int unsigned CNT_W = 8;

  // One captured request: direction, byte address, write data.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_req_t;

  // One response: error flag plus read data (0 for writes and errors).
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } apb_rsp_t;

  // Window check done in 33 bits so base+size can never wrap past 2^32.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Address window decoder: flags a request whose address falls in [BASE, BASE+SIZE).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output simply follows addr_i.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE = SLAVE_ADDR,
  parameter logic [31:0] SIZE = SLAVE_SIZE
) (
  input  logic [31:0] addr_i,
  output logic        hit_o
);

  assign hit_o = in_window(addr_i, BASE, SIZE);

endmodule

// File: rtl/apb_master.sv
// Request-driven APB master: turns single valid/ready requests into SETUP/ACCESS transfers.
// Latency: 3 cycles accept->rsp_valid with zero waits, +1 per wait state; decode miss answers next cycle.
// Backpressure: req_ready only in IDLE (one request in flight); responses are one-cycle pulses, never stalled.
module apb_master #(
  // Maximum ACCESS cycles with pready low before abort; legal range 2..255.
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] SLAVE_SIZE = apb_pkg::SLAVE_SIZE
) (
  input  logic        pclk,
  input  logic        preset,
  // Request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // Response side
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // APB side
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);
  import apb_pkg::*;

  // Count value at which a still-waiting ACCESS cycle aborts.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             psel_q;
  logic             penable_q;
  apb_req_t         xfer_q;
  logic             rsp_vld_q;
  apb_rsp_t         rsp_q;

  apb_req_t         req_d;
  logic [31:0]      rdata_d;
  logic             hit;
  logic             idle_like;
  logic             accept;
  logic             tmo_hit;

  // Window check on the raw request address.
  apb_addr_decode #(
    .BASE (SLAVE_ADDR),
    .SIZE (SLAVE_SIZE)
  ) u_decode (
    .addr_i (req_addr),
    .hit_o  (hit)
  );

  // The unused 2'b11 encoding behaves exactly like IDLE.
  assign idle_like = (state_q != ST_SETUP) && (state_q != ST_ACCESS);
  assign req_ready = idle_like && !preset;
  assign accept    = req_valid && req_ready;
  assign tmo_hit   = (cnt_q == TMO_LAST);

  // Request capture value and completion data (writes return zero).
  always_comb begin
    req_d       = '0;
    req_d.write = req_write;
    req_d.addr  = req_addr;
    req_d.wdata = req_wdata;
    rdata_d     = xfer_q.write ? 32'h0 : prdata;
  end

  // Transfer FSM with registered APB controls, timeout counter and response pulse.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      xfer_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      // Response is a single-cycle pulse; data is zero whenever it is not valid.
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
      case (state_q)
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          psel_q    <= 1'b1;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            // Completion takes priority over a timeout on the same cycle.
            state_q    <= ST_IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            rsp_vld_q  <= 1'b1;
            rsp_q.err  <= 1'b0;
            rsp_q.rdata <= rdata_d;
          end else if (tmo_hit) begin
            state_q    <= ST_IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            rsp_vld_q  <= 1'b1;
            rsp_q.err  <= 1'b1;
            rsp_q.rdata <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // IDLE (and the illegal encoding): bus quiet, address/data hold last values.
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (accept) begin
            if (hit) begin
              state_q <= ST_SETUP;
              psel_q  <= 1'b1;
              xfer_q  <= req_d;
            end else begin
              // Decode miss never touches the bus; answer with an error next cycle.
              rsp_vld_q   <= 1'b1;
              rsp_q.err   <= 1'b1;
              rsp_q.rdata <= 32'h0;
            end
          end
        end
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = xfer_q.write;
  assign paddr     = xfer_q.addr;
  assign pwdata    = xfer_q.wdata;
  assign rsp_valid = rsp_vld_q;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = rsp_q.rdata;

endmodule
